pipe_stage: RTL

- Parametrised successor to the fixed IF/ID-style stage latch.
- Carries {inst_addr, inst} between any two pipeline stages with a valid/ready handshake, synchronous flush with NOP insertion, hold, and a saturating stall-cycle counter.
- Instantiated between IF/ID, ID/EXE and later stage pairs in the core top.

---
 rtl/pipe_stage_pkg.sv | 24 ++
 rtl/pipe_stage_slot.sv | 69 ++++++
 rtl/pipe_stage.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pipe_stage_pkg.sv
// Shared widths, bubble encoding and slot operation codes for pipe_stage.
// The optional skid entry is enabled with the PIPE_STAGE_SKID_EN macro.
`ifndef PIPE_STAGE_DEFINES
`define PIPE_STAGE_DEFINES
`define ADDR_WIDTH 32
`define DATA_WIDTH 32
`define INST_NOP 32'h0000_0013
`endif

package pipe_stage_pkg;

    localparam int unsigned ADDR_W_DEF = `ADDR_WIDTH;
    localparam int unsigned INST_W_DEF = `DATA_WIDTH;
    localparam logic [31:0] NOP_INST_DEF = `INST_NOP;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        SLOT_HOLD  = 2'd0,
        SLOT_LOAD  = 2'd1,
        SLOT_CLEAR = 2'd2,
        SLOT_FLUSH = 2'd3
    } slot_op_e;

endpackage

// File: rtl/pipe_stage_slot.sv
// stage_slot: one payload register with valid bit, load, clear-to-NOP and flush.
// CLEAR keeps the address, FLUSH zeroes it as well.
module stage_slot
    import pipe_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  slot_op_e          op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [INST_W-1:0] inst_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [INST_W-1:0] inst_o
);

    logic              valid_d, valid_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [INST_W-1:0] inst_d, inst_q;

    // Next payload state from the requested slot operation.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        case (op_i)
            SLOT_LOAD: begin
                valid_d = 1'b1;
                addr_d  = addr_i;
                inst_d  = inst_i;
            end
            SLOT_CLEAR: begin
                valid_d = 1'b0;
                inst_d  = NOP_INST;
            end
            SLOT_FLUSH: begin
                valid_d = 1'b0;
                addr_d  = {ADDR_W{1'b0}};
                inst_d  = NOP_INST;
            end
            default: begin
                valid_d = valid_q;
                addr_d  = addr_q;
                inst_d  = inst_q;
            end
        endcase
    end

    // Payload register, asynchronously reset to an empty NOP slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            inst_q  <= NOP_INST;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline latch with flush, hold and saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry and decouple in_ready_o from out_ready_i.
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF),
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic [INST_W-1:0] inst_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [INST_W-1:0] inst_o,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              accept_s;
    logic              fire_s;
    logic              in_ready_s;
    slot_op_e          main_op_s;
    logic [ADDR_W-1:0] main_addr_in_s;
    logic [INST_W-1:0] main_inst_in_s;
    logic              main_valid_s;
    logic [ADDR_W-1:0] main_addr_s;
    logic [INST_W-1:0] main_inst_s;
    logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;

    stage_slot #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .NOP_INST (NOP_INST)
    ) u_main (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .op_i    (main_op_s),
        .addr_i  (main_addr_in_s),
        .inst_i  (main_inst_in_s),
        .valid_o (main_valid_s),
        .addr_o  (main_addr_s),
        .inst_o  (main_inst_s)
    );

`ifdef PIPE_STAGE_SKID_EN
    slot_op_e          skid_op_s;
    logic              skid_valid_s;
    logic [ADDR_W-1:0] skid_addr_s;
    logic [INST_W-1:0] skid_inst_s;

    stage_slot #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .NOP_INST (NOP_INST)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .op_i    (skid_op_s),
        .addr_i  (inst_addr_i),
        .inst_i  (inst_i),
        .valid_o (skid_valid_s),
        .addr_o  (skid_addr_s),
        .inst_o  (skid_inst_s)
    );

    // Two-entry steering: the skid refills main on fire so order is preserved.
    always_comb begin
        in_ready_s     = !skid_valid_s && !hold_i;
        fire_s         = main_valid_s && out_ready_i && !hold_i;
        accept_s       = in_valid_i && in_ready_s;
        main_op_s      = SLOT_HOLD;
        skid_op_s      = SLOT_HOLD;
        main_addr_in_s = inst_addr_i;
        main_inst_in_s = inst_i;
        if (flush_i) begin
            main_op_s = SLOT_FLUSH;
            skid_op_s = SLOT_FLUSH;
        end else if (fire_s) begin
            if (skid_valid_s) begin
                main_op_s      = SLOT_LOAD;
                main_addr_in_s = skid_addr_s;
                main_inst_in_s = skid_inst_s;
                skid_op_s      = SLOT_CLEAR;
            end else if (accept_s) begin
                main_op_s = SLOT_LOAD;
            end else begin
                main_op_s = SLOT_CLEAR;
            end
        end else if (accept_s) begin
            if (main_valid_s) begin
                skid_op_s = SLOT_LOAD;
            end else begin
                main_op_s = SLOT_LOAD;
            end
        end else begin
            main_op_s = SLOT_HOLD;
            skid_op_s = SLOT_HOLD;
        end
    end
`else
    // Single entry: ready only when empty or draining this cycle.
    always_comb begin
        in_ready_s     = !hold_i && (!main_valid_s || out_ready_i);
        fire_s         = main_valid_s && out_ready_i && !hold_i;
        accept_s       = in_valid_i && in_ready_s;
        main_op_s      = SLOT_HOLD;
        main_addr_in_s = inst_addr_i;
        main_inst_in_s = inst_i;
        if (flush_i) begin
            main_op_s = SLOT_FLUSH;
        end else if (accept_s) begin
            main_op_s = SLOT_LOAD;
        end else if (fire_s) begin
            main_op_s = SLOT_CLEAR;
        end else begin
            main_op_s = SLOT_HOLD;
        end
    end
`endif

    // Stall counter saturates at all-ones; flush does not clear it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_s && !fire_s) begin
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready_o  = in_ready_s;
    assign out_valid_o = main_valid_s;
    assign inst_addr_o = main_addr_s;
    assign inst_o      = main_inst_s;
    assign stall_cnt_o = stall_cnt_q;

endmodule
